// File: rtl/sdram_arb_sched_pkg.sv
// sdram_arb_sched_pkg: shared scheduler encodings and defaults.
// Holds the arbiter FSM state type and the refresh interval default.
package sdram_arb_sched_pkg;

  typedef enum logic [1:0] {
    A_IDLE = 2'd0,
    A_REF  = 2'd1,
    A_CMD  = 2'd2,
    A_WAIT = 2'd3
  } arb_state_e;

  localparam int REF_CYCLES_DEF = 1000;

endpackage

// File: rtl/sdram_rr_arb.sv
// sdram_rr_arb: combinational round-robin pick.
// Ports: req (request vector), ptr (last winner) -> gnt (one-hot), idx, any.
module sdram_rr_arb #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  int          j;
  logic [PW-1:0] jj;

  // Scan starting one past the last winner so it goes to the back.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    for (int k = 1; k <= N; k++) begin
      j  = (int'(ptr) + k) % N;
      jj = PW'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/sdram_arb_sched.sv
// sdram_arb_sched: round-robin port scheduler with refresh priority.
// Ports: core handshake (ref/rd/wr req+ack, addr), per-port req/grant/done.
module sdram_arb_sched
  import sdram_arb_sched_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_W     = 24,
  parameter int REF_CYCLES = REF_CYCLES_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sdram_init_done,
  input  logic                        core_idle,
  output logic                        sdram_ref_req,
  input  logic                        sdram_ref_ack,
  output logic                        sdram_rd_req,
  input  logic                        sdram_rd_ack,
  output logic                        sdram_wr_req,
  input  logic                        sdram_wr_ack,
  input  logic                        sdram_wr_data_valid,
  output logic [ADDR_W-1:0]           sdram_addr,
  input  logic [NUM_PORTS-1:0]        port_req,
  input  logic [NUM_PORTS-1:0]        port_rnw,
  input  logic [NUM_PORTS*ADDR_W-1:0] port_addr,
  output logic [NUM_PORTS-1:0]        port_grant,
  output logic [NUM_PORTS-1:0]        port_wr_valid,
  output logic [NUM_PORTS-1:0]        port_done,
  output logic                        ref_overrun
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(REF_CYCLES);

  arb_state_e     state;
  logic [PW-1:0]  ptr;
  logic [CW-1:0]  ref_cnt;
  logic           ref_pend;
  logic           ref_wrap;

  logic [NUM_PORTS-1:0] win_oh;
  logic [PW-1:0]        win_idx;
  logic                 win_any;
  logic [ADDR_W-1:0]    win_addr;

  sdram_rr_arb #(
    .N  (NUM_PORTS),
    .PW (PW)
  ) u_arb (
    .req (port_req),
    .ptr (ptr),
    .gnt (win_oh),
    .idx (win_idx),
    .any (win_any)
  );

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (win_idx == PW'(i))
        win_addr = port_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign port_wr_valid = port_grant
                       & {NUM_PORTS{sdram_wr_data_valid}};

  assign ref_wrap = sdram_init_done
                  && (ref_cnt == CW'(REF_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt     <= '0;
      ref_pend    <= 1'b0;
      ref_overrun <= 1'b0;
    end else begin
      if (!sdram_init_done || ref_wrap)
        ref_cnt <= '0;
      else
        ref_cnt <= ref_cnt + 1'b1;
      // A fresh interval outranks a same-cycle ack.
      if (ref_wrap) begin
        ref_pend <= 1'b1;
        if (ref_pend && !sdram_ref_ack)
          ref_overrun <= 1'b1;
      end else if (sdram_ref_ack) begin
        ref_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= A_IDLE;
      ptr           <= PW'(NUM_PORTS - 1);
      sdram_ref_req <= 1'b0;
      sdram_rd_req  <= 1'b0;
      sdram_wr_req  <= 1'b0;
      sdram_addr    <= '0;
      port_grant    <= '0;
      port_done     <= '0;
    end else begin
      port_done <= '0;
      case (state)
        A_IDLE: begin
          if (sdram_init_done && core_idle) begin
            if (ref_pend) begin
              sdram_ref_req <= 1'b1;
              state         <= A_REF;
            end else if (win_any) begin
              port_grant   <= win_oh;
              sdram_addr   <= win_addr;
              sdram_rd_req <= port_rnw[win_idx];
              sdram_wr_req <= !port_rnw[win_idx];
              ptr          <= win_idx;
              state        <= A_CMD;
            end
          end
        end
        A_REF: begin
          if (sdram_ref_ack) begin
            sdram_ref_req <= 1'b0;
            state         <= A_WAIT;
          end
        end
        A_CMD: begin
          if ((sdram_rd_req && sdram_rd_ack)
              || (sdram_wr_req && sdram_wr_ack)) begin
            sdram_rd_req <= 1'b0;
            sdram_wr_req <= 1'b0;
            state        <= A_WAIT;
          end
        end
        A_WAIT: begin
          if (core_idle) begin
            port_done  <= port_grant;
            port_grant <= '0;
            state      <= A_IDLE;
          end
        end
        default: state <= A_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arb_sched.sv
// tb_sdram_arb_sched: directed bench for the SDRAM scheduler.
// Table-driven arbitration vectors plus refresh/overrun/reset sequences.
module tb_sdram_arb_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sdram_init_done;
  logic        core_idle;
  logic        sdram_ref_req;
  logic        sdram_ref_ack;
  logic        sdram_rd_req;
  logic        sdram_rd_ack;
  logic        sdram_wr_req;
  logic        sdram_wr_ack;
  logic        sdram_wr_data_valid;
  logic [23:0] sdram_addr;
  logic [3:0]  port_req;
  logic [3:0]  port_rnw;
  logic [95:0] port_addr;
  logic [3:0]  port_grant;
  logic [3:0]  port_wr_valid;
  logic [3:0]  port_done;
  logic        ref_overrun;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sdram_arb_sched #(
    .NUM_PORTS  (4),
    .ADDR_W     (24),
    .REF_CYCLES (16)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .sdram_init_done     (sdram_init_done),
    .core_idle           (core_idle),
    .sdram_ref_req       (sdram_ref_req),
    .sdram_ref_ack       (sdram_ref_ack),
    .sdram_rd_req        (sdram_rd_req),
    .sdram_rd_ack        (sdram_rd_ack),
    .sdram_wr_req        (sdram_wr_req),
    .sdram_wr_ack        (sdram_wr_ack),
    .sdram_wr_data_valid (sdram_wr_data_valid),
    .sdram_addr          (sdram_addr),
    .port_req            (port_req),
    .port_rnw            (port_rnw),
    .port_addr           (port_addr),
    .port_grant          (port_grant),
    .port_wr_valid       (port_wr_valid),
    .port_done           (port_done),
    .ref_overrun         (ref_overrun)
  );

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  rnw;
    logic [3:0]  gnt;
    logic        rd;
    logic [23:0] addr;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n               = 1'b0;
    sdram_init_done     = 1'b0;
    core_idle           = 1'b1;
    sdram_ref_ack       = 1'b0;
    sdram_rd_ack        = 1'b0;
    sdram_wr_ack        = 1'b0;
    sdram_wr_data_valid = 1'b0;
    port_req            = '0;
    port_rnw            = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic serve_ref();
    @(negedge clk);
    sdram_ref_ack = 1'b1;
    core_idle     = 1'b0;
    @(negedge clk);
    sdram_ref_ack = 1'b0;
    repeat (2) @(negedge clk);
    core_idle = 1'b1;
  endtask

  task automatic do_xfer(input vec_t v);
    logic got;
    @(negedge clk);
    port_req = v.req;
    port_rnw = v.rnw;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (port_grant != 0) begin
        got = 1'b1;
        break;
      end
      if (sdram_ref_req) serve_ref();
    end
    chk("grant_seen", 32'(got), 32'd1);
    if (!got) return;
    chk("grant", 32'(port_grant), 32'(v.gnt));
    chk("rd_req", 32'(sdram_rd_req), 32'(v.rd));
    chk("wr_req", 32'(sdram_wr_req), 32'(!v.rd));
    chk("addr", 32'(sdram_addr), 32'(v.addr));
    @(negedge clk);
    sdram_wr_data_valid = 1'b1;
    #1;
    chk("wr_valid_on", 32'(port_wr_valid), 32'(v.gnt));
    sdram_wr_data_valid = 1'b0;
    #1;
    chk("wr_valid_off", 32'(port_wr_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("req_hold",
        32'(sdram_rd_req | sdram_wr_req), 32'd1);
    chk("addr_hold", 32'(sdram_addr), 32'(v.addr));
    @(negedge clk);
    sdram_rd_ack = v.rd;
    sdram_wr_ack = !v.rd;
    core_idle    = 1'b0;
    @(posedge clk);
    #1;
    chk("req_drop",
        32'(sdram_rd_req | sdram_wr_req), 32'd0);
    chk("grant_wait", 32'(port_grant), 32'(v.gnt));
    @(negedge clk);
    sdram_rd_ack = 1'b0;
    sdram_wr_ack = 1'b0;
    @(negedge clk);
    chk("done_early", 32'(port_done), 32'd0);
    core_idle = 1'b1;
    @(posedge clk);
    #1;
    chk("done", 32'(port_done), 32'(v.gnt));
    chk("grant_clr", 32'(port_grant), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    port_addr = {24'hFFFFFF, 24'hABCDEF,
                 24'h001234, 24'h000100};
    vt[0] = '{4'b0101, 4'b1111, 4'b0001, 1'b1, 24'h000100};
    vt[1] = '{4'b0101, 4'b1111, 4'b0100, 1'b1, 24'hABCDEF};
    vt[2] = '{4'b0101, 4'b1111, 4'b0001, 1'b1, 24'h000100};
    vt[3] = '{4'b0010, 4'b0000, 4'b0010, 1'b0, 24'h001234};
    vt[4] = '{4'b1111, 4'b1011, 4'b0100, 1'b0, 24'hABCDEF};
    vt[5] = '{4'b1001, 4'b0000, 4'b1000, 1'b0, 24'hFFFFFF};
    vt[6] = '{4'b1111, 4'b1111, 4'b0001, 1'b1, 24'h000100};
    vt[7] = '{4'b0110, 4'b1111, 4'b0010, 1'b1, 24'h001234};

    rst_n = 1'b0;
    do_reset();
    #1;
    chk("rst_grant", 32'(port_grant), 32'd0);
    chk("rst_ref", 32'(sdram_ref_req), 32'd0);
    chk("rst_rd", 32'(sdram_rd_req), 32'd0);
    chk("rst_wr", 32'(sdram_wr_req), 32'd0);
    chk("rst_addr", 32'(sdram_addr), 32'd0);
    chk("rst_done", 32'(port_done), 32'd0);
    chk("rst_ovr", 32'(ref_overrun), 32'd0);

    // Refresh cadence: 16 counts to wrap, one more edge to issue.
    @(negedge clk);
    sdram_init_done = 1'b1;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (sdram_ref_req) begin
        n = k;
        break;
      end
    end
    chk("ref_rise_cycle", 32'(n), 32'd17);
    serve_ref();
    chk("ref_fall", 32'(sdram_ref_req), 32'd0);

    do_reset();
    sdram_init_done = 1'b1;
    for (int i = 0; i < 8; i++) do_xfer(vt[i]);
    @(negedge clk);
    port_req = '0;
    chk("no_overrun", 32'(ref_overrun), 32'd0);

    // Refresh and a port request meet in the same idle cycle.
    do_reset();
    sdram_init_done = 1'b1;
    core_idle       = 1'b0;
    port_req        = 4'b0001;
    port_rnw        = 4'b0001;
    repeat (20) @(negedge clk);
    core_idle = 1'b1;
    @(posedge clk);
    #1;
    chk("prio_ref", 32'(sdram_ref_req), 32'd1);
    chk("prio_nogrant", 32'(port_grant), 32'd0);
    @(negedge clk);
    sdram_ref_ack = 1'b1;
    core_idle     = 1'b0;
    @(posedge clk);
    #1;
    chk("prio_ref_drop", 32'(sdram_ref_req), 32'd0);
    @(negedge clk);
    sdram_ref_ack = 1'b0;
    @(negedge clk);
    core_idle = 1'b1;
    @(posedge clk);
    #1;
    chk("prio_wait_grant", 32'(port_grant), 32'd0);
    chk("prio_ref_nodone", 32'(port_done), 32'd0);
    @(posedge clk);
    #1;
    chk("prio_grant", 32'(port_grant), 32'd1);
    chk("prio_rd", 32'(sdram_rd_req), 32'd1);
    @(negedge clk);
    sdram_rd_ack = 1'b1;
    core_idle    = 1'b0;
    @(negedge clk);
    sdram_rd_ack = 1'b0;
    @(negedge clk);
    core_idle = 1'b1;
    @(posedge clk);
    #1;
    chk("prio_done", 32'(port_done), 32'd1);
    @(negedge clk);
    port_req = '0;

    // Unacked refresh across a second wrap flags overrun.
    do_reset();
    sdram_init_done = 1'b1;
    repeat (31) @(posedge clk);
    #1;
    chk("ovr_before", 32'(ref_overrun), 32'd0);
    chk("ovr_req_held", 32'(sdram_ref_req), 32'd1);
    @(posedge clk);
    #1;
    chk("ovr_set", 32'(ref_overrun), 32'd1);
    @(negedge clk);
    sdram_ref_ack = 1'b1;
    core_idle     = 1'b0;
    @(posedge clk);
    #1;
    chk("ovr_ref_drop", 32'(sdram_ref_req), 32'd0);
    @(negedge clk);
    sdram_ref_ack = 1'b0;
    core_idle     = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("ovr_sticky", 32'(ref_overrun), 32'd1);

    // Reset in the middle of a command restarts the pointer.
    do_reset();
    sdram_init_done = 1'b1;
    port_req        = 4'b0100;
    port_rnw        = 4'b0100;
    @(posedge clk);
    #1;
    chk("mid_grant", 32'(port_grant), 32'b0100);
    chk("mid_rd", 32'(sdram_rd_req), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_grant", 32'(port_grant), 32'd0);
    chk("async_rd", 32'(sdram_rd_req), 32'd0);
    chk("async_addr", 32'(sdram_addr), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    port_req = 4'b1111;
    port_rnw = 4'b1111;
    @(posedge clk);
    #1;
    chk("post_rst_grant", 32'(port_grant), 32'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
